mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 28 ++
 rtl/mc_if.sv | 41 ++++
 rtl/mc_decode.sv | 23 ++
 rtl/mc_controller.sv | 146 ++++++++++++++
 tb/tb_mc_controller.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared opcode and FSM state definitions for the multicycle controller.
package mc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_LW  = 2'b01,
      OP_SW  = 2'b10,
      OP_J   = 2'b11
   } opcode_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_t;

   // A jump by -1 lands on its own address (pc has already been incremented).
   localparam logic [1:0] IMM_SELF = 2'b11;

   function automatic logic [7:0] sext2(input logic [1:0] v);
      return {{6{v[1]}}, v};
   endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath/instruction-memory bundle; master is the environment, slave the controller.
// The retired port exists only when MC_RETIRE_CNT_EN is defined.
interface mc_if;
   logic       run;
   logic [7:0] instruction;
   logic [7:0] pc;
   logic [1:0] rs_addr;
   logic [1:0] rt_addr;
   logic [1:0] wr_addr;
   logic [7:0] imm;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic       alu_src;
   logic       mem_to_reg;
   logic [2:0] state;
   logic       halted;
`ifdef MC_RETIRE_CNT_EN
   logic [15:0] retired;
`endif

   modport master (
      output run, instruction,
      input  pc, rs_addr, rt_addr, wr_addr, imm,
      input  reg_write, mem_read, mem_write, alu_src, mem_to_reg,
`ifdef MC_RETIRE_CNT_EN
      input  retired,
`endif
      input  state, halted
   );

   modport slave (
      input  run, instruction,
      output pc, rs_addr, rt_addr, wr_addr, imm,
      output reg_write, mem_read, mem_write, alu_src, mem_to_reg,
`ifdef MC_RETIRE_CNT_EN
      output retired,
`endif
      output state, halted
   );
endinterface

// File: rtl/mc_decode.sv
// Combinational IR decode: register selects, sign-extended immediate, opcode class, self-jump detect.
// Zero latency; no flow control.
module mc_decode
   import mc_pkg::*;
(
   input  logic [7:0] ir,
   output opcode_t    op,
   output logic [1:0] rs_addr,
   output logic [1:0] rt_addr,
   output logic [1:0] wr_addr,
   output logic [7:0] imm,
   output logic       is_halt
);

   assign op      = opcode_t'(ir[7:6]);
   assign rs_addr = ir[5:4];
   assign rt_addr = ir[3:2];
   // lw writes its rt field; every other format names rd in the low bits.
   assign wr_addr = (op == OP_LW) ? ir[3:2] : ir[1:0];
   assign imm     = sext2(ir[1:0]);
   assign is_halt = (op == OP_J) && (ir[1:0] == IMM_SELF);

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller: 3-5 cycles per instruction (add 4, lw 5, sw 4, j 3); run is a level enable sampled only
// at instruction boundaries, a self-jump parks in HALT until reset. MC_RETIRE_CNT_EN adds a retired counter.
module mc_controller
   import mc_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00
)
(
   input  logic clk,
   input  logic reset,
   mc_if.slave  bus
);

   state_t     st;
   logic [7:0] pc_q;
   logic [7:0] ir;
   logic       halt_pend;
   logic       halted_q;
   logic       reg_write_q;
   logic       mem_read_q;
   logic       mem_write_q;
   logic       alu_src_q;
   logic       mem_to_reg_q;

   opcode_t    op;
   logic [7:0] imm;
   logic       is_halt;
   state_t     done_st;

   mc_decode u_decode (
      .ir      (ir),
      .op      (op),
      .rs_addr (bus.rs_addr),
      .rt_addr (bus.rt_addr),
      .wr_addr (bus.wr_addr),
      .imm     (imm),
      .is_halt (is_halt)
   );

   assign done_st = bus.run ? FETCH : IDLE;

   // Controls are registered on entry to the state in which they are valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st           <= IDLE;
         pc_q         <= RESET_PC;
         ir           <= 8'h00;
         halt_pend    <= 1'b0;
         halted_q     <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         alu_src_q    <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else begin
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         alu_src_q    <= 1'b0;
         mem_to_reg_q <= 1'b0;
         unique case (st)
            IDLE: begin
               if (bus.run) st <= FETCH;
            end
            FETCH: begin
               ir   <= bus.instruction;
               pc_q <= pc_q + 8'd1;
               st   <= DECODE;
            end
            DECODE: begin
               halt_pend <= is_halt;
               alu_src_q <= (op == OP_LW) || (op == OP_SW);
               st        <= EXEC;
            end
            EXEC: begin
               unique case (op)
                  OP_ADD: begin
                     reg_write_q <= 1'b1;
                     st          <= WB;
                  end
                  OP_LW: begin
                     mem_read_q <= 1'b1;
                     alu_src_q  <= 1'b1;
                     st         <= MEM;
                  end
                  OP_SW: begin
                     mem_write_q <= 1'b1;
                     alu_src_q   <= 1'b1;
                     st          <= MEM;
                  end
                  OP_J: begin
                     pc_q     <= pc_q + imm;
                     halted_q <= halt_pend;
                     st       <= halt_pend ? HALT : done_st;
                  end
               endcase
            end
            MEM: begin
               if (op == OP_LW) begin
                  reg_write_q  <= 1'b1;
                  mem_to_reg_q <= 1'b1;
                  alu_src_q    <= 1'b1;
                  st           <= WB;
               end else begin
                  st <= done_st;
               end
            end
            WB: begin
               st <= done_st;
            end
            default: begin
               st <= HALT;
            end
         endcase
      end
   end

   assign bus.pc         = pc_q;
   assign bus.imm        = imm;
   assign bus.reg_write  = reg_write_q;
   assign bus.mem_read   = mem_read_q;
   assign bus.mem_write  = mem_write_q;
   assign bus.alu_src    = alu_src_q;
   assign bus.mem_to_reg = mem_to_reg_q;
   assign bus.state      = st;
   assign bus.halted     = halted_q;

`ifdef MC_RETIRE_CNT_EN
   logic [15:0] retired_q;
   logic        retire;

   // An instruction retires on the edge that leaves its final state, halting jumps included.
   assign retire = (st == WB) || ((st == MEM) && (op == OP_SW)) || ((st == EXEC) && (op == OP_J));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired_q <= 16'h0000;
      end else if (retire && (retired_q != 16'hFFFF)) begin
         retired_q <= retired_q + 16'd1;
      end
   end

   assign bus.retired = retired_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instruction-schedule model checked every cycle plus directed literal checks.
`define CHK(n, a, e) check(n, 16'(a), 16'(e))

module tb_mc_controller;
   import mc_pkg::*;

   logic       clk;
   logic       reset;
   logic [7:0] imem [256];

   mc_if bus();

   mc_controller #(.RESET_PC(8'h00)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.instruction = imem[bus.pc];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // ctl bit order: {reg_write, mem_read, mem_write, alu_src, mem_to_reg}
   localparam logic [4:0] C_NONE = 5'b00000;
   localparam logic [4:0] C_RW   = 5'b10000;
   localparam logic [4:0] C_MR   = 5'b01000;
   localparam logic [4:0] C_MW   = 5'b00100;
   localparam logic [4:0] C_AS   = 5'b00010;
   localparam logic [4:0] C_MTR  = 5'b00001;

   typedef struct {
      logic [2:0] st;
      logic [7:0] pc;
      logic [7:0] ir;
      logic [4:0] ctl;
      logic       hlt;
      logic       last;
      logic [7:0] pa;
   } rec_t;

   rec_t        q[$];
   rec_t        cur;
   logic        cur_vld = 1'b0;
   logic [7:0]  m_pc;
   logic [7:0]  m_ir;
   logic [15:0] m_ret;

   function automatic logic [7:0] sx(input logic [1:0] v);
      return v[1] ? {6'b111111, v} : {6'b000000, v};
   endfunction

   function automatic rec_t mk(input logic [2:0] st, input logic [7:0] pc, input logic [7:0] ir,
                               input logic [4:0] ctl, input logic hlt, input logic last, input logic [7:0] pa);
      rec_t r;
      r.st = st; r.pc = pc; r.ir = ir; r.ctl = ctl; r.hlt = hlt; r.last = last; r.pa = pa;
      return r;
   endfunction

   // Queue up the whole cycle-by-cycle schedule of the instruction sitting at p0.
   task automatic build(input logic [7:0] p0);
      logic [7:0] ir, p1, tgt;
      ir  = imem[p0];
      p1  = p0 + 8'd1;
      tgt = p1 + sx(ir[1:0]);
      q.push_back(mk(FETCH, p0, m_ir, C_NONE, 1'b0, 1'b0, p0));
      q.push_back(mk(DECODE, p1, ir, C_NONE, 1'b0, 1'b0, p1));
      case (ir[7:6])
         2'b00: begin
            q.push_back(mk(EXEC, p1, ir, C_NONE, 1'b0, 1'b0, p1));
            q.push_back(mk(WB, p1, ir, C_RW, 1'b0, 1'b1, p1));
         end
         2'b01: begin
            q.push_back(mk(EXEC, p1, ir, C_AS, 1'b0, 1'b0, p1));
            q.push_back(mk(MEM, p1, ir, C_MR | C_AS, 1'b0, 1'b0, p1));
            q.push_back(mk(WB, p1, ir, C_RW | C_MTR | C_AS, 1'b0, 1'b1, p1));
         end
         2'b10: begin
            q.push_back(mk(EXEC, p1, ir, C_AS, 1'b0, 1'b0, p1));
            q.push_back(mk(MEM, p1, ir, C_MW | C_AS, 1'b0, 1'b1, p1));
         end
         default: begin
            q.push_back(mk(EXEC, p1, ir, C_NONE, 1'b0, 1'b1, tgt));
            if (ir[1:0] == 2'b11) q.push_back(mk(HALT, tgt, ir, C_NONE, 1'b1, 1'b0, tgt));
         end
      endcase
      m_ir = ir;
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         m_pc    = 8'h00;
         m_ir    = 8'h00;
         m_ret   = 16'h0000;
         cur     = mk(IDLE, 8'h00, 8'h00, C_NONE, 1'b0, 1'b0, 8'h00);
         cur_vld = 1'b1;
      end else if (cur.st != HALT) begin
         if (cur.last) begin
            m_pc = cur.pa;
            if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
         end
         if (q.size() == 0 && bus.run) build(m_pc);
         if (q.size() != 0) cur = q.pop_front();
         else cur = mk(IDLE, m_pc, m_ir, C_NONE, 1'b0, 1'b0, m_pc);
      end
   end

   task automatic compare();
      logic [1:0] op;
      op = cur.ir[7:6];
      `CHK("state", bus.state, cur.st);
      `CHK("pc", bus.pc, cur.pc);
      `CHK("rs_addr", bus.rs_addr, cur.ir[5:4]);
      `CHK("rt_addr", bus.rt_addr, cur.ir[3:2]);
      `CHK("imm", bus.imm, sx(cur.ir[1:0]));
      if (op == 2'b00) `CHK("wr_addr_add", bus.wr_addr, cur.ir[1:0]);
      else if (op == 2'b01) `CHK("wr_addr_lw", bus.wr_addr, cur.ir[3:2]);
      `CHK("reg_write", bus.reg_write, cur.ctl[4]);
      `CHK("mem_read", bus.mem_read, cur.ctl[3]);
      `CHK("mem_write", bus.mem_write, cur.ctl[2]);
      `CHK("alu_src", bus.alu_src, cur.ctl[1]);
      `CHK("mem_to_reg", bus.mem_to_reg, cur.ctl[0]);
      `CHK("halted", bus.halted, cur.hlt);
`ifdef MC_RETIRE_CNT_EN
      `CHK("retired", bus.retired, m_ret);
`endif
   endtask

   always @(negedge clk) begin
      if (cur_vld) begin
         compare();
         checks++;
         if (bus.state !== cur.st) begin
            errors++;
            $display("FAIL model_state at t=%0t: got %0h, expected %0h", $time, bus.state, cur.st);
         end
         checks++;
         if (bus.pc !== cur.pc) begin
            errors++;
            $display("FAIL model_pc at t=%0t: got %0h, expected %0h", $time, bus.pc, cur.pc);
         end
      end
   end

   task automatic wait_st(input logic [2:0] s, input logic [7:0] p, input int budget, input string nm);
      int   n;
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         @(negedge clk);
         n++;
         hit = (bus.state == s) && (bus.pc == p);
      end
      `CHK(nm, hit, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      bus.run = 1'b0;
      for (int i = 0; i < 256; i++) imem[8'(i)] = 8'h00;
      imem[0] = 8'h49;   // lw  rt=2 imm=+1
      imem[1] = 8'hC1;   // j   +1
      imem[3] = 8'h1B;   // add rs=1 rt=2 rd=3
      imem[4] = 8'hA9;   // sw  rs=2 rt=2 imm=+1
      for (int i = 5; i < 13; i++) imem[8'(i)] = {2'b00, 6'(i * 7)};
      imem[13] = 8'hC3;  // j -1: self loop

      repeat (2) @(posedge clk);
      #2;
      `CHK("rst_state", bus.state, IDLE);
      `CHK("rst_pc", bus.pc, 8'h00);
      `CHK("rst_halted", bus.halted, 1'b0);
      `CHK("rst_reg_write", bus.reg_write, 1'b0);
      reset   = 1'b0;
      bus.run = 1'b1;

      // lw 0x49
      @(negedge clk); `CHK("lw_idle", bus.state, IDLE);
      @(negedge clk); `CHK("lw_c1_state", bus.state, FETCH); `CHK("lw_c1_pc", bus.pc, 8'h00);
      @(negedge clk); `CHK("lw_c2_pc", bus.pc, 8'h01); `CHK("lw_c2_rt", bus.rt_addr, 2'd2);
      @(negedge clk); `CHK("lw_c3_alu_src", bus.alu_src, 1'b1);
      @(negedge clk); `CHK("lw_c4_mem_read", bus.mem_read, 1'b1); `CHK("lw_c4_state", bus.state, MEM);
      @(negedge clk); `CHK("lw_c5_reg_write", bus.reg_write, 1'b1);
                      `CHK("lw_c5_wr_addr", bus.wr_addr, 2'd2);
                      `CHK("lw_c5_mem_to_reg", bus.mem_to_reg, 1'b1);
      // j +1 at pc 1
      @(negedge clk); `CHK("j_c1_state", bus.state, FETCH); `CHK("j_c1_pc", bus.pc, 8'h01);
      @(negedge clk); `CHK("j_c2_state", bus.state, DECODE);
      @(negedge clk); `CHK("j_c3_state", bus.state, EXEC);
                      `CHK("j_c3_reg_write", bus.reg_write, 1'b0);
                      `CHK("j_c3_mem_write", bus.mem_write, 1'b0);
      @(negedge clk); `CHK("j_next_state", bus.state, FETCH); `CHK("j_target_pc", bus.pc, 8'h03);
      // add 0x1B at pc 3
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); `CHK("add_wb_reg_write", bus.reg_write, 1'b1); `CHK("add_wb_wr_addr", bus.wr_addr, 2'd3);
      // sw 0xA9 at pc 4, run dropped in DECODE
      @(negedge clk); `CHK("sw_fetch_pc", bus.pc, 8'h04);
      @(negedge clk); `CHK("sw_decode", bus.state, DECODE);
      bus.run = 1'b0;
      @(negedge clk); `CHK("sw_exec", bus.state, EXEC);
      @(negedge clk); `CHK("sw_mem_write", bus.mem_write, 1'b1); `CHK("sw_mem_read", bus.mem_read, 1'b0);
      @(negedge clk); `CHK("sw_then_idle", bus.state, IDLE); `CHK("sw_next_pc", bus.pc, 8'h05);
      @(negedge clk); `CHK("sw_stay_idle", bus.state, IDLE);

      // adds 5..12 then self-jump at 13
      bus.run = 1'b1;
      wait_st(HALT, 8'h0D, 80, "reach_halt");
      `CHK("halt_flag", bus.halted, 1'b1);
      for (int i = 0; i < 6; i++) begin
         bus.run = ~bus.run;
         @(negedge clk);
         `CHK("halt_stays", bus.state, HALT);
         `CHK("halt_pc", bus.pc, 8'h0D);
      end

      // reset from HALT, then async reset in MEM of lw
      #2 reset = 1'b1;
      bus.run = 1'b0;
      #1;
      `CHK("halt_rst_state", bus.state, IDLE);
      `CHK("halt_rst_halted", bus.halted, 1'b0);
      @(posedge clk);
      #2 reset = 1'b0;
      bus.run = 1'b1;
      wait_st(MEM, 8'h01, 10, "lw_reach_mem");
      `CHK("lw2_mem_read", bus.mem_read, 1'b1);
      #2 reset = 1'b1;
      #1;
      `CHK("async_mem_read", bus.mem_read, 1'b0);
      `CHK("async_state", bus.state, IDLE);
      `CHK("async_pc", bus.pc, 8'h00);
      `CHK("async_alu_src", bus.alu_src, 1'b0);
      `CHK("async_rt", bus.rt_addr, 2'd0);

      // j -2 from pc 0 lands at 0xFF; fetch there wraps pc to 0x00
      imem[0]   = 8'hC2;
      imem[255] = 8'h06;  // add rd=2
      @(posedge clk);
      #2 reset = 1'b0;
      wait_st(FETCH, 8'hFF, 20, "reach_ff");
      @(negedge clk);
      `CHK("wrap_pc", bus.pc, 8'h00);
      `CHK("wrap_state", bus.state, DECODE);
      bus.run = 1'b0;
      repeat (3) @(negedge clk);
      `CHK("wrap_idle", bus.state, IDLE);
      `CHK("wrap_idle_pc", bus.pc, 8'h00);
`ifdef MC_RETIRE_CNT_EN
      `CHK("wrap_retired", bus.retired, 16'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
